// File: rtl/sdram_chip_ctrl.sv
// sdram_chip_ctrl
//   Single-port SDRAM controller for chip RAM, CLK80 domain only.
//   Performs the power-up init sequence, then serves closed-page single-word
//   reads/writes through a REQ/ACK handshake. Periodic auto-refresh is owned
//   internally and always wins over a new request at IDLE, but never cuts
//   into an access already in progress.
// Ports
//   CLK80, RESET          clock, synchronous active-high reset
//   REQ, WR, ADDR, WDATA, BE   request side ({bank,row,col} address)
//   ACK, RDATA, READY     completion pulse, read data, init done
//   CSn/RASn/CASn/WEn, BA, A, DQM, DQ_OUT, DQ_OE, CKE, DQ_IN   SDRAM pins
// All pin outputs come straight from flops. Wait parameters T_RFC, T_RP and
// T_WR+T_RP must be at least 2 (the state ahead of IDLE exits one cycle early
// so IDLE can issue the next command exactly on the timing boundary).
module sdram_chip_ctrl #(
  parameter int unsigned ROW_W     = 13,
  parameter int unsigned COL_W     = 9,
  parameter int unsigned BANK_W    = 2,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CL        = 2,
  parameter int unsigned T_RP      = 2,
  parameter int unsigned T_RCD     = 2,
  parameter int unsigned T_RFC     = 6,
  parameter int unsigned T_WR      = 2,
  parameter int unsigned INIT_WAIT = 16000,
  parameter int unsigned REF_INT   = 624
) (
  input  logic                           CLK80,
  input  logic                           RESET,
  input  logic                           REQ,
  input  logic                           WR,
  input  logic [BANK_W+ROW_W+COL_W-1:0]  ADDR,
  input  logic [DATA_W-1:0]              WDATA,
  input  logic [DATA_W/8-1:0]            BE,
  input  logic [DATA_W-1:0]              DQ_IN,
  output logic                           ACK,
  output logic [DATA_W-1:0]              RDATA,
  output logic                           READY,
  output logic                           CSn,
  output logic                           RASn,
  output logic                           CASn,
  output logic                           WEn,
  output logic [BANK_W-1:0]              BA,
  output logic [ROW_W-1:0]               A,
  output logic [DATA_W/8-1:0]            DQM,
  output logic [DATA_W-1:0]              DQ_OUT,
  output logic                           DQ_OE,
  output logic                           CKE
);

  localparam int unsigned DM_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(INIT_WAIT) + 1;
  localparam int unsigned TMR_W = $clog2(REF_INT);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
    S_IDLE, S_REF, S_ACT, S_RW, S_RDWAIT, S_RECOV
  } state_t;

  // {CSn,RASn,CASn,WEn}; all-ones (deselect) serves as NOP
  typedef enum logic [3:0] {
    CMD_MRS   = 4'b0000,
    CMD_REF   = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_ACT   = 4'b0011,
    CMD_WRITE = 4'b0100,
    CMD_READ  = 4'b0101,
    CMD_NOP   = 4'b1111
  } cmd_t;

  state_t              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [1:0]          pend_q, pend_d;
  logic [BANK_W-1:0]   ba_q, ba_d;
  logic [ROW_W-1:0]    a_q, a_d;
  logic [DM_W-1:0]     dqm_q, dqm_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                wr_q, wr_d;
  logic                cke_q;

  logic                tmr_wrap;
  logic                take_ref;
  logic [CNT_W-1:0]    rec_last;

  always_comb begin
    state_d  = state_q;
    cmd_d    = CMD_NOP;
    cnt_d    = cnt_q + 1'b1;
    ba_d     = ba_q;
    a_d      = a_q;
    dqm_d    = dqm_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    ready_d  = ready_q;
    wr_d     = wr_q;
    take_ref = 1'b0;
    rec_last = wr_q ? CNT_W'(T_WR + T_RP - 2) : CNT_W'(T_RP - 2);

    tmr_wrap = (tmr_q == TMR_W'(REF_INT - 1));
    tmr_d    = tmr_wrap ? '0 : tmr_q + 1'b1;

    unique case (state_q)
      S_INIT_WAIT: if (cnt_q == CNT_W'(INIT_WAIT - 1)) begin
        cmd_d   = CMD_PRE;
        a_d     = '0;
        a_d[10] = 1'b1;
        cnt_d   = '0;
        state_d = S_INIT_PRE;
      end
      S_INIT_PRE: if (cnt_q == CNT_W'(T_RP - 1)) begin
        cmd_d   = CMD_REF;
        cnt_d   = '0;
        state_d = S_INIT_REF1;
      end
      S_INIT_REF1: if (cnt_q == CNT_W'(T_RFC - 1)) begin
        cmd_d   = CMD_REF;
        cnt_d   = '0;
        state_d = S_INIT_REF2;
      end
      S_INIT_REF2: if (cnt_q == CNT_W'(T_RFC - 1)) begin
        // Mode register: burst length 1, sequential, CAS latency CL
        cmd_d    = CMD_MRS;
        ba_d     = '0;
        a_d      = '0;
        a_d[6:4] = 3'(CL);
        cnt_d    = '0;
        state_d  = S_INIT_MRS;
      end
      S_INIT_MRS: if (cnt_q == CNT_W'(1)) begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (pend_q != 2'd0) begin
          cmd_d    = CMD_REF;
          take_ref = 1'b1;
          state_d  = S_REF;
        end else if (REQ) begin
          cmd_d   = CMD_ACT;
          ba_d    = ADDR[COL_W+ROW_W +: BANK_W];
          a_d     = ADDR[COL_W +: ROW_W];
          wr_d    = WR;
          state_d = S_ACT;
        end
      end
      S_REF: if (cnt_q == CNT_W'(T_RFC - 2)) state_d = S_IDLE;
      S_ACT: if (cnt_q == CNT_W'(T_RCD - 1)) begin
        // Column command with auto-precharge (A[10]) keeps the page closed
        a_d                = '0;
        a_d[COL_W-1:0]     = ADDR[COL_W-1:0];
        a_d[10]            = 1'b1;
        cnt_d              = '0;
        state_d            = S_RW;
        if (wr_q) begin
          cmd_d    = CMD_WRITE;
          dq_oe_d  = 1'b1;
          dq_out_d = WDATA;
          dqm_d    = ~BE;
        end else begin
          cmd_d = CMD_READ;
          dqm_d = '0;
        end
      end
      S_RW: begin
        cnt_d = '0;
        if (wr_q) begin
          ack_d   = 1'b1;
          dqm_d   = '1;
          state_d = S_RECOV;
        end else begin
          state_d = S_RDWAIT;
        end
      end
      S_RDWAIT: if (cnt_q == CNT_W'(CL - 1)) begin
        rdata_d = DQ_IN;
        ack_d   = 1'b1;
        dqm_d   = '1;
        cnt_d   = '0;
        state_d = S_RECOV;
      end
      S_RECOV: if (cnt_q == rec_last) state_d = S_IDLE;
      default: state_d = S_INIT_WAIT;
    endcase

    // Backlog resets when init completes; refreshes owed during init are moot
    pend_d = pend_q;
    if (ready_d && !ready_q)                  pend_d = 2'd0;
    else if (tmr_wrap && !take_ref && pend_q != 2'd3) pend_d = pend_q + 2'd1;
    else if (!tmr_wrap && take_ref)           pend_d = pend_q - 2'd1;
  end

  always_ff @(posedge CLK80) begin
    if (RESET) begin
      state_q  <= S_INIT_WAIT;
      cmd_q    <= CMD_NOP;
      cnt_q    <= '0;
      tmr_q    <= '0;
      pend_q   <= '0;
      ba_q     <= '0;
      a_q      <= '0;
      dqm_q    <= '1;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      wr_q     <= 1'b0;
      cke_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      pend_q   <= pend_d;
      ba_q     <= ba_d;
      a_q      <= a_d;
      dqm_q    <= dqm_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      wr_q     <= wr_d;
      cke_q    <= 1'b1;
    end
  end

  assign {CSn, RASn, CASn, WEn} = cmd_q;
  assign BA     = ba_q;
  assign A      = a_q;
  assign DQM    = dqm_q;
  assign DQ_OUT = dq_out_q;
  assign DQ_OE  = dq_oe_q;
  assign ACK    = ack_q;
  assign RDATA  = rdata_q;
  assign READY  = ready_q;
  assign CKE    = cke_q;

endmodule

// File: tb/tb_sdram_chip_ctrl.sv
`timescale 1ns/1ps
module tb_sdram_chip_ctrl;

  localparam int unsigned ROW_W     = 13;
  localparam int unsigned COL_W     = 9;
  localparam int unsigned BANK_W    = 2;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CL        = 2;
  localparam int unsigned T_RP      = 2;
  localparam int unsigned T_RCD     = 2;
  localparam int unsigned T_RFC     = 6;
  localparam int unsigned T_WR      = 2;
  localparam int unsigned INIT_WAIT = 16000;
  localparam int unsigned REF_INT   = 624;

  localparam logic [3:0] C_MRS = 4'b0000, C_REF = 4'b0001, C_PRE = 4'b0010,
                         C_ACT = 4'b0011, C_WRC = 4'b0100, C_RDC = 4'b0101,
                         C_NOP = 4'b1111;

  logic                          CLK80, RESET, REQ, WR;
  logic [BANK_W+ROW_W+COL_W-1:0] ADDR;
  logic [DATA_W-1:0]             WDATA, DQ_IN, RDATA, DQ_OUT;
  logic [1:0]                    BE, DQM;
  logic                          ACK, READY, CSn, RASn, CASn, WEn, DQ_OE, CKE;
  logic [BANK_W-1:0]             BA;
  logic [ROW_W-1:0]              A;
  logic [3:0]                    cmd;

  sdram_chip_ctrl #(
    .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .DATA_W(DATA_W), .CL(CL),
    .T_RP(T_RP), .T_RCD(T_RCD), .T_RFC(T_RFC), .T_WR(T_WR),
    .INIT_WAIT(INIT_WAIT), .REF_INT(REF_INT)
  ) dut (
    .CLK80(CLK80), .RESET(RESET), .REQ(REQ), .WR(WR), .ADDR(ADDR),
    .WDATA(WDATA), .BE(BE), .DQ_IN(DQ_IN), .ACK(ACK), .RDATA(RDATA),
    .READY(READY), .CSn(CSn), .RASn(RASn), .CASn(CASn), .WEn(WEn),
    .BA(BA), .A(A), .DQM(DQM), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .CKE(CKE)
  );

  assign cmd = {CSn, RASn, CASn, WEn};

  initial CLK80 = 1'b0;
  always #5 CLK80 = ~CLK80;

  // Edges since the last edge that sampled RESET high
  int unsigned n = 0;
  always @(posedge CLK80) n <= RESET ? 0 : n + 1;

  // One-word SDRAM model: byte-masked write capture, read data driven on the
  // pins only in the cycle the controller must sample it
  logic [15:0]   mem = 16'hBE11;
  logic [CL-1:0] rd_pipe = '0;
  logic [15:0]   mask;
  assign mask  = {{8{DQM[1]}}, {8{DQM[0]}}};
  assign DQ_IN = rd_pipe[CL-1] ? mem : 16'hDEAD;
  always @(posedge CLK80) begin
    rd_pipe <= {rd_pipe[CL-2:0], (cmd == C_RDC)};
    if (cmd == C_WRC && DQ_OE) mem <= (mem & mask) | (DQ_OUT & ~mask);
  end

  // Bus monitor: refresh count and refreshes landing inside an access
  int unsigned ref_cnt = 0, ref_viol = 0, ack_cnt = 0;
  logic busy = 1'b0;
  always @(negedge CLK80) begin
    if (RESET) busy = 1'b0;
    else begin
      if (cmd == C_ACT) busy = 1'b1;
      if (cmd == C_REF) begin
        ref_cnt++;
        if (busy) ref_viol++;
      end
      if (ACK) begin
        ack_cnt++;
        busy = 1'b0;
      end
    end
  end

  int unsigned errors = 0, checks = 0;

  task automatic tick();
    @(posedge CLK80);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nops(input int unsigned k, input string tag);
    int unsigned bad;
    bad = 0;
    repeat (k) begin
      tick();
      if (cmd !== C_NOP || ACK !== 1'b0) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic init_seq(input string tag);
    int unsigned bad;
    bad = 0;
    for (int i = 1; i < INIT_WAIT; i++) begin
      tick();
      if (cmd !== C_NOP || READY !== 1'b0 || ACK !== 1'b0) bad++;
    end
    chk({tag, "_nops"}, bad, 0);
    tick();
    chk({tag, "_pre"}, cmd, C_PRE);
    chk({tag, "_pre_a10"}, A[10], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned target, r0, v0, a0, got;
    RESET = 1'b1; REQ = 1'b0; WR = 1'b0; ADDR = '0; WDATA = '0; BE = '0;

    // 1: reset values, then init sequence
    repeat (4) tick();
    chk("rst_cmd", cmd, C_NOP);
    chk("rst_a", A, 0);
    chk("rst_ba", BA, 0);
    chk("rst_dqm", DQM, 2'b11);
    chk("rst_oe", DQ_OE, 0);
    chk("rst_ack", ACK, 0);
    chk("rst_ready", READY, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_cke", CKE, 1);
    RESET = 1'b0;
    init_seq("init");
    nops(T_RP - 1, "gap_pre");
    tick(); chk("init_ref1", cmd, C_REF);
    nops(T_RFC - 1, "gap_ref1");
    tick(); chk("init_ref2", cmd, C_REF);
    nops(T_RFC - 1, "gap_ref2");
    tick(); chk("init_mrs", cmd, C_MRS);
    chk("init_mrs_a", A, 13'h020);
    chk("init_mrs_ba", BA, 0);
    chk("init_mrs_ready", READY, 0);
    tick(); chk("ready_early", READY, 0);
    tick(); chk("ready_up", READY, 1);

    // 2: write, low byte only
    REQ = 1'b1; WR = 1'b1; ADDR = {2'd1, 13'h0ABC, 9'h055};
    WDATA = 16'hBEEF; BE = 2'b01;
    tick();
    chk("wr_act", cmd, C_ACT);
    chk("wr_act_ba", BA, 1);
    chk("wr_act_a", A, 13'h0ABC);
    nops(T_RCD - 1, "wr_trcd");
    tick();
    chk("wr_cmd", cmd, C_WRC);
    chk("wr_cmd_a", A, 13'h0455);
    chk("wr_dqm", DQM, 2'b10);
    chk("wr_oe", DQ_OE, 1);
    chk("wr_dq", DQ_OUT, 16'hBEEF);
    chk("wr_ack_early", ACK, 0);
    tick();
    chk("wr_ack", ACK, 1);
    chk("wr_oe_off", DQ_OE, 0);
    chk("wr_dqm_off", DQM, 2'b11);
    chk("wr_mem", mem, 16'hBEEF);
    REQ = 1'b0;
    tick(); chk("wr_ack_pulse", ACK, 0);
    repeat (2) tick();

    // 3: read back, latency 6 from REQ
    REQ = 1'b1; WR = 1'b0;
    tick(); chk("rd_act", cmd, C_ACT); chk("rd_act_a", A, 13'h0ABC);
    tick();
    tick(); chk("rd_cmd", cmd, C_RDC); chk("rd_cmd_a", A, 13'h0455);
    chk("rd_dqm", DQM, 2'b00); chk("rd_oe", DQ_OE, 0);
    tick(); chk("rd_ack_e1", ACK, 0);
    tick(); chk("rd_ack_e2", ACK, 0);
    tick(); chk("rd_ack", ACK, 1); chk("rd_data", RDATA, 16'hBEEF);
    REQ = 1'b0;
    tick(); chk("rd_ack_pulse", ACK, 0); chk("rd_hold", RDATA, 16'hBEEF);

    // 4: request and refresh expiry seen in the same IDLE cycle
    target = ((n / REF_INT) + 1) * REF_INT;
    repeat (target - n) tick();
    REQ = 1'b1; WR = 1'b0; ADDR = {2'd2, 13'h1234, 9'h0AA};
    tick(); chk("tie_ref_first", cmd, C_REF);
    nops(T_RFC - 1, "tie_trfc");
    tick(); chk("tie_act", cmd, C_ACT);
    chk("tie_act_ba", BA, 2); chk("tie_act_a", A, 13'h1234);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      if (ACK === 1'b1) got = 1;
    end
    chk("tie_ack", got, 1);
    chk("tie_rdata", RDATA, 16'hBEEF);
    REQ = 1'b0;

    // 5: continuous requests across three refresh intervals
    r0 = ref_cnt; v0 = ref_viol; a0 = ack_cnt;
    REQ = 1'b1;
    repeat (3 * REF_INT) tick();
    REQ = 1'b0;
    repeat (20) tick();
    chk("stream_refs", ref_cnt - r0, 3);
    chk("stream_ref_in_access", ref_viol - v0, 0);
    chk("stream_acks", ((ack_cnt - a0) >= 250) ? 1 : 0, 1);

    // 6: reset while waiting for read data
    REQ = 1'b1; WR = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      if (cmd === C_RDC) got = 1;
    end
    chk("abort_read_seen", got, 1);
    tick(); chk("abort_pre_ack", ACK, 0);
    RESET = 1'b1; REQ = 1'b0;
    tick();
    chk("abort_cmd", cmd, C_NOP);
    chk("abort_oe", DQ_OE, 0);
    chk("abort_ack", ACK, 0);
    chk("abort_ready", READY, 0);
    chk("abort_rdata", RDATA, 0);
    chk("abort_dqm", DQM, 2'b11);
    RESET = 1'b0;
    init_seq("reinit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
